mdu_ctrl: RTL and testbench

//  Sequencer for the E-stage multiply/divide resource and the HI/LO registers.

---
 rtl/mdu_ctrl.sv | 145 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer with HI/LO registers: computes into shadow registers on issue,
// then commits HI/LO after a fixed latency while exporting Busy to the stall unit.
module mdu_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic        cancel_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       shi_q, shi_d, slo_q, slo_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;

  logic              accept;
  logic [63:0]       prod_s, prod_u;
  logic [31:0]       div_b, abs_a, abs_b, q_mag, r_mag;
  logic [31:0]       quot_s, rem_s, quot_u, rem_u;

  // Full 64-bit products from explicitly extended operands.
  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Signed division on magnitudes; the -2^31 / -1 case naturally yields 0x80000000 rem 0.
  // A zero divisor is replaced so the datapath never divides by zero; the result is discarded.
  assign div_b  = (b_i == 32'd0) ? 32'd1 : b_i;
  assign abs_a  = a_i[31]   ? (32'd0 - a_i)   : a_i;
  assign abs_b  = div_b[31] ? (32'd0 - div_b) : div_b;
  assign q_mag  = abs_a / abs_b;
  assign r_mag  = abs_a % abs_b;
  assign quot_s = (a_i[31] ^ b_i[31]) ? (32'd0 - q_mag) : q_mag;
  assign rem_s  = a_i[31] ? (32'd0 - r_mag) : r_mag;
  assign quot_u = a_i / div_b;
  assign rem_u  = a_i % div_b;

  assign accept = start_i & ~cancel_i & (state_q == S_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shi_q   <= '0;
      slo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_i)
            OP_MULT: begin
              {shi_d, slo_d} = prod_s;
              cnt_d          = MULT_LOAD;
              state_d        = S_RUN;
            end
            OP_MULTU: begin
              {shi_d, slo_d} = prod_u;
              cnt_d          = MULT_LOAD;
              state_d        = S_RUN;
            end
            OP_DIV: begin
              shi_d   = (b_i == 32'd0) ? hi_q : rem_s;
              slo_d   = (b_i == 32'd0) ? lo_q : quot_s;
              cnt_d   = DIV_LOAD;
              state_d = S_RUN;
            end
            OP_DIVU: begin
              shi_d   = (b_i == 32'd0) ? hi_q : rem_u;
              slo_d   = (b_i == 32'd0) ? lo_q : quot_u;
              cnt_d   = DIV_LOAD;
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = a_i;
            OP_MTLO: lo_d = a_i;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_ONE) begin
          hi_d    = shi_q;
          lo_d    = slo_q;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == S_RUN);
    done_o = done_q;
    hi_o   = hi_q;
    lo_o   = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized operations checked
// against a transaction-level HI/LO model.
module tb_mdu_ctrl;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic        cancel_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i), .cancel_i(cancel_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result of a mult/div op given the current HI/LO: returns {HI, LO}.
  function automatic logic [63:0] model_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
    longint          ps;
    longint unsigned pu;
    int              sa, sb;
    logic [31:0]     q, r;
    case (op)
      3'd0: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        return ps;
      end
      3'd1: begin
        pu = longint'(a) * longint'(b);
        return pu;
      end
      3'd2: begin
        if (b == 32'd0) return {hi, lo};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issue a mult/div; optionally throw a stray Start (any op, random Cancel) at a RUN cycle.
  task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit stray);
    int          n;
    int          sc;
    logic [63:0] res;
    n   = (op == 3'd2 || op == 3'd3) ? DIV_CYC : MULT_CYC;
    res = model_md(op, a, b, m_hi, m_lo);
    sc  = stray ? int'($urandom_range(1, n)) : 0;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; cancel_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 1; c <= n; c++) begin
      check("busy_run", 64'(busy_o), 64'd1);
      check("done_run", 64'(done_o), 64'd0);
      check("hi_hold", 64'(hi_o), 64'(m_hi));
      check("lo_hold", 64'(lo_o), 64'(m_lo));
      if (c == sc) begin
        start_i  = 1'b1;
        op_i     = 3'($urandom_range(0, 7));
        a_i      = $urandom;
        b_i      = $urandom;
        cancel_i = 1'($urandom_range(0, 1));
      end else begin
        start_i  = 1'b0;
        cancel_i = 1'b0;
      end
      @(negedge clk_i);
    end
    start_i = 1'b0; cancel_i = 1'b0;
    {m_hi, m_lo} = res;
    check("busy_end", 64'(busy_o), 64'd0);
    check("done_pulse", 64'(done_o), 64'd1);
    check("hi_commit", 64'(hi_o), 64'(m_hi));
    check("lo_commit", 64'(lo_o), 64'(m_lo));
    $display("[TB] md op=%0d a=%h b=%h stray=%0d -> hi=%h lo=%h", op, a, b, sc, hi_o, lo_o);
  endtask

  // Single-cycle issue that must never start a run: mthi/mtlo, cancelled or reserved ops.
  task automatic do_idle_op(input logic [2:0] op, input logic [31:0] a, input bit cancel);
    start_i = 1'b1; op_i = op; a_i = a; b_i = $urandom; cancel_i = cancel;
    @(negedge clk_i);
    start_i = 1'b0; cancel_i = 1'b0;
    if (!cancel && op == 3'd4) m_hi = a;
    if (!cancel && op == 3'd5) m_lo = a;
    check("busy_idle", 64'(busy_o), 64'd0);
    check("done_idle", 64'(done_o), 64'd0);
    check("hi_idle", 64'(hi_o), 64'(m_hi));
    check("lo_idle", 64'(lo_o), 64'(m_lo));
    $display("[TB] idle op=%0d a=%h cancel=%0d -> hi=%h lo=%h", op, a, cancel, hi_o, lo_o);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] op;
    repeat (3) @(negedge clk_i);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // mult / multu
    do_md(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("t2_mult_hi", 64'(hi_o), 64'h0000_0000_FFFF_FFFF);
    check("t2_mult_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFFA);
    do_md(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("t2_multu_hi", 64'(hi_o), 64'h0000_0000_0000_0002);
    check("t2_multu_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFFA);

    // div and divide by zero (HI/LO unchanged)
    do_md(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("t3_div_hi", 64'(hi_o), 64'h0000_0000_FFFF_FFFF);
    check("t3_div_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFFD);
    do_md(3'd3, 32'd7, 32'd0, 1'b0);
    check("t3_divu0_hi", 64'(hi_o), 64'h0000_0000_FFFF_FFFF);
    check("t3_divu0_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFFD);
    @(negedge clk_i);

    // mthi/mtlo, cancel, reserved opcodes
    do_idle_op(3'd4, 32'h0000_1234, 1'b0);
    check("t4_mthi", 64'(hi_o), 64'h0000_0000_0000_1234);
    do_idle_op(3'd5, 32'h0000_5678, 1'b0);
    do_idle_op(3'd0, 32'h1111_1111, 1'b1);
    do_idle_op(3'd4, 32'h2222_2222, 1'b1);
    do_idle_op(3'd6, 32'h3333_3333, 1'b0);
    do_idle_op(3'd7, 32'h4444_4444, 1'b0);

    // mthi during RUN is ignored; HI changes only at the mult commit
    start_i = 1'b1; op_i = 3'd0; a_i = 32'd6; b_i = 32'd7; cancel_i = 1'b0;
    @(negedge clk_i);
    op_i = 3'd4; a_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    start_i = 1'b0;
    check("t4_mthi_run_busy", 64'(busy_o), 64'd1);
    check("t4_mthi_run_hi", 64'(hi_o), 64'(m_hi));
    repeat (MULT_CYC - 1) @(negedge clk_i);
    {m_hi, m_lo} = {32'd0, 32'd42};
    check("t4_commit_done", 64'(done_o), 64'd1);
    check("t4_commit_hi", 64'(hi_o), 64'(m_hi));
    check("t4_commit_lo", 64'(lo_o), 64'(m_lo));
    @(negedge clk_i);
    check("t5_single_done", 64'(done_o), 64'd0);
    check("t5_no_restart", 64'(busy_o), 64'd0);

    // overflow, then back-to-back issue in the Done cycle
    do_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("t6_ovf_hi", 64'(hi_o), 64'd0);
    check("t6_ovf_lo", 64'(lo_o), 64'h0000_0000_8000_0000);
    do_md(3'd1, 32'h0001_0000, 32'h0001_0000, 1'b1);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op <= 3'd3) do_md(op, rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
      else do_idle_op(op, $urandom, 1'($urandom_range(0, 3) == 0));
    end
    @(negedge clk_i);

    // asynchronous reset in the middle of a divide: immediate clear, no later commit
    do_md(3'd1, 32'h0000_0100, 32'h0000_0100, 1'b0);
    @(negedge clk_i);
    start_i = 1'b1; op_i = 3'd3; a_i = 32'd100; b_i = 32'd7; cancel_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check("t1_async_busy", 64'(busy_o), 64'd0);
    check("t1_async_done", 64'(done_o), 64'd0);
    check("t1_async_hi", 64'(hi_o), 64'd0);
    check("t1_async_lo", 64'(lo_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < DIV_CYC + 2; c++) begin
      @(negedge clk_i);
      check("t1_post_busy", 64'(busy_o), 64'd0);
      check("t1_post_done", 64'(done_o), 64'd0);
      check("t1_post_hilo", {hi_o, lo_o}, 64'd0);
    end
    do_md(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
